line_cmd_queue: RTL and testbench
=================================

// Module: line_cmd_queue
// PURPOSE
//  CPU-facing command queue that sits directly upstream of LineEngine.
//  MMIO stores stage line endpoints and colour, then a GO store pushes one command into a FIFO.
//  A drain FSM replays each queued command into LineEngine's serial load protocol:
//  colour, x0, y0, x1, then y1 with trigger. It waits on LE_ready between commands.
//  This decouples the CPU from LineEngine draw latency.
// PARAMETERS
//  DEPTH   8   FIFO entries (power of 2, >=2)
//  AW      3   log2(DEPTH); count width is AW+1
// PORTS
//  clk             in   1   system clock, all logic posedge
//  rst_n           in   1   asynchronous active-low reset
//  cpu_we          in   1   MMIO write strobe, one cycle per store
//  cpu_addr        in   3   register select (see BEHAVIOUR)
//  cpu_wdata       in   32  store data
//  q_full          out  1   FIFO holds DEPTH entries
//  q_count         out  AW+1 entries queued (excludes command being drained)
//  q_overflow      out  1   sticky: a GO was dropped because FIFO was full
//  q_idle          out  1   FIFO empty & FSM in IDLE & LE_ready
//  LE_ready        in   1   LineEngine can accept a new line
//  LE_color        out  32  colour to LineEngine
//  LE_point        out  10  coordinate bus to LineEngine
//  LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid  out 1 each
//  LE_trigger      out  1   start draw; asserted with LE_y1_valid
// BEHAVIOUR
//  Reset: FIFO empty, staging regs 0, q_overflow 0, FSM IDLE, all LE_* outputs 0.
//  Reset is async and may occur mid-drain; it abandons the in-flight command and flushes the queue.
//  cpu_addr map:
//   0 COLOR<=wdata[31:0]; 1 X0; 2 Y0; 3 X1; 4 Y1 (each <=wdata[9:0], upper bits ignored)
//   5 GO: push {COLOR,X0,Y0,X1,Y1}; 6 CLR: q_overflow<=0; 7 ignored
//  Staging regs keep their values after GO, so a repeated GO re-queues the same line.
//  Push on GO while full: the entry is dropped and q_overflow<=1. Pop is unaffected.
//  Push and pop in the same cycle are both legal, even when full; q_count is then unchanged.
//  The pop happens in the same cycle as the push, so the freed slot accepts the push.
//  GO when empty: the entry is visible to the FSM on the next cycle (1-cycle min latency).
//  FSM states: IDLE, COLOR, X0, Y0, X1, Y1T, GAP. All LE_* outputs are registered.
//   IDLE: when !empty && LE_ready, pop the head into the cur register, then go to COLOR.
//   COLOR: LE_color=cur.color, LE_color_valid=1 -> X0
//   X0: LE_point=x0, LE_x0_valid=1 -> Y0
//   Y0: LE_point=y0, LE_y0_valid=1 -> X1
//   X1: LE_point=x1, LE_x1_valid=1 -> Y1T
//   Y1T: LE_point=y1, LE_y1_valid=1, LE_trigger=1 -> GAP
//   GAP: all valids 0. LE_ready is ignored for this one cycle (engine ready drops late). -> IDLE
//  Exactly one valid is high per cycle. LE_color and LE_point hold their last value otherwise.
//  Per-command cost is 7 cycles min, or 6 cycles with colour skip.
// CONFIGURATION
//  LQ_SKIP_COLOR_EN defined:
//   - Keep last_color plus a last_color_vld flag (cleared on reset).
//   - IDLE jumps straight to X0 when cur.color==last_color && last_color_vld.
//   - No LE_color_valid pulse is emitted for that command.
//  Undefined: every command emits the COLOR cycle.
// STRUCTURE
//  Shared package line_cmd_pkg holds:
//   - address constants LQ_A_COLOR..LQ_A_CLR
//   - FSM state encodings
//   - LQ_ENTRY_W=72 and the field offsets {color[71:40],x0,y0,x1,y1}
//  Sub-module line_cmd_fifo: sync FIFO (DEPTH x 72) with push/pop/full/empty/count.
//  The FSM and MMIO decode live in the top module.
// TESTING
//  1 Store C=0x007F0000, X0=0x100, Y0=0, X1=0x100, Y1=0x100, then GO, with LE_ready=1:
//    -> color_valid, x0, y0, x1 pulses, then y1+trigger, on consecutive cycles with matching values.
//  2 Queue 3 GOs, hold LE_ready=0 for 20 cycles:
//    -> no valids, q_count=3. Release ready: commands drain in FIFO order, and q_count decrements.
//  3 DEPTH=8 with LE_ready=0, then 9 GOs:
//    -> q_full=1, q_count=8, q_overflow=1. CLR store -> q_overflow=0.
//  4 FIFO full; GO lands in the cycle IDLE pops:
//    -> no overflow, q_count stays 8, and the new entry drains last.
//  5 rst_n low during the X1 state:
//    -> all LE_* =0 immediately, q_count=0, FSM IDLE. Nothing further is emitted after release.
//  6 With LQ_SKIP_COLOR_EN: two GOs with the same colour:
//    -> second command has no LE_color_valid and takes 6 cycles. A different colour restores the COLOR cycle.

Source files
------------

// File: rtl/line_cmd_pkg.sv
// Package: line_cmd_pkg
// Shared constants and types for the LineEngine command queue: MMIO register addresses, drain FSM
// state encodings, the 72-bit queue entry layout {color[71:40], x0, y0, x1, y1} and a packing
// helper. Imported by line_cmd_fifo and line_cmd_queue.

package line_cmd_pkg;

    // MMIO register map; address 7 has no register and is ignored.
    localparam logic [2:0] LQ_A_COLOR = 3'd0;
    localparam logic [2:0] LQ_A_X0    = 3'd1;
    localparam logic [2:0] LQ_A_Y0    = 3'd2;
    localparam logic [2:0] LQ_A_X1    = 3'd3;
    localparam logic [2:0] LQ_A_Y1    = 3'd4;
    localparam logic [2:0] LQ_A_GO    = 3'd5;
    localparam logic [2:0] LQ_A_CLR   = 3'd6;

    // Drain FSM states.
    localparam logic [2:0] LQ_ST_IDLE  = 3'd0;
    localparam logic [2:0] LQ_ST_COLOR = 3'd1;
    localparam logic [2:0] LQ_ST_X0    = 3'd2;
    localparam logic [2:0] LQ_ST_Y0    = 3'd3;
    localparam logic [2:0] LQ_ST_X1    = 3'd4;
    localparam logic [2:0] LQ_ST_Y1T   = 3'd5;
    localparam logic [2:0] LQ_ST_GAP   = 3'd6;

    // One-hot valid vector, MSB first: {color, x0, y0, x1, y1}.
    localparam logic [4:0] LQ_V_COLOR = 5'b10000;
    localparam logic [4:0] LQ_V_X0    = 5'b01000;
    localparam logic [4:0] LQ_V_Y0    = 5'b00100;
    localparam logic [4:0] LQ_V_X1    = 5'b00010;
    localparam logic [4:0] LQ_V_Y1    = 5'b00001;

    // Queue entry layout.
    localparam int unsigned LQ_ENTRY_W   = 72;
    localparam int unsigned LQ_COLOR_LSB = 40;
    localparam int unsigned LQ_X0_LSB    = 30;
    localparam int unsigned LQ_Y0_LSB    = 20;
    localparam int unsigned LQ_X1_LSB    = 10;
    localparam int unsigned LQ_Y1_LSB    = 0;

    typedef struct packed {
        logic [9:0] x0;
        logic [9:0] y0;
        logic [9:0] x1;
        logic [9:0] y1;
    } lq_pts_t;

    // Field order matches the *_LSB offsets above.
    typedef struct packed {
        logic [31:0] color;
        lq_pts_t     pts;
    } lq_entry_t;

    function automatic logic [LQ_ENTRY_W-1:0] lq_pack(
        input logic [31:0] color,
        input logic [9:0]  x0,
        input logic [9:0]  y0,
        input logic [9:0]  x1,
        input logic [9:0]  y1
    );
        logic [LQ_ENTRY_W-1:0] e;
        e                       = '0;
        e[LQ_COLOR_LSB +: 32]   = color;
        e[LQ_X0_LSB    +: 10]   = x0;
        e[LQ_Y0_LSB    +: 10]   = y0;
        e[LQ_X1_LSB    +: 10]   = x1;
        e[LQ_Y1_LSB    +: 10]   = y1;
        return e;
    endfunction

endpackage

// File: rtl/line_cmd_queue_if.sv
// Interface: line_cmd_queue_if
// Serial load bus between the command queue (master) and LineEngine (slave).
//   LE_ready                 engine -> queue  engine can accept a new line
//   LE_color[31:0]           queue -> engine  colour word
//   LE_point[9:0]            queue -> engine  coordinate bus
//   LE_{color,x0,y0,x1,y1}_valid  queue -> engine  one-hot load strobes
//   LE_trigger               queue -> engine  start draw, asserted with LE_y1_valid

interface line_cmd_queue_if;
    logic        LE_ready;
    logic [31:0] LE_color;
    logic [9:0]  LE_point;
    logic        LE_color_valid;
    logic        LE_x0_valid;
    logic        LE_y0_valid;
    logic        LE_x1_valid;
    logic        LE_y1_valid;
    logic        LE_trigger;

    modport master (
        input  LE_ready,
        output LE_color, LE_point, LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid,
               LE_y1_valid, LE_trigger
    );

    modport slave (
        output LE_ready,
        input  LE_color, LE_point, LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid,
               LE_y1_valid, LE_trigger
    );
endinterface

// File: rtl/line_cmd_fifo.sv
// Module: line_cmd_fifo
// Synchronous FIFO, DEPTH x W, first-word-fall-through read port.
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata  write request; accepted when not full, or when full and popping the same cycle
//   pop, rdata   read request; rdata always shows the head entry
//   full, empty  occupancy flags
//   count        entries held (AW+1 bits)

module line_cmd_fifo
    import line_cmd_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned W     = LQ_ENTRY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot being written (wr_ptr == rd_ptr).
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/line_cmd_queue.sv
// Module: line_cmd_queue
// CPU-facing command queue in front of LineEngine. MMIO stores stage colour and endpoints; a GO
// store pushes the staged line into a FIFO. A drain FSM replays each entry over the serial load
// bus: colour, x0, y0, x1, then y1 with trigger, followed by one gap cycle.
//   clk, rst_n          clock, asynchronous active-low reset (abandons any in-flight command)
//   cpu_we/addr/wdata   MMIO store port (0 COLOR, 1 X0, 2 Y0, 3 X1, 4 Y1, 5 GO, 6 CLR)
//   q_full, q_count     FIFO status; q_count excludes the command being drained
//   q_overflow          sticky: a GO was dropped on a full FIFO; cleared by CLR
//   q_idle              FIFO empty, FSM idle and engine ready
//   le                  LineEngine load bus (master side)
// Build option: define LQ_SKIP_COLOR_EN to skip the colour cycle when a command's colour matches
// the last colour sent to the engine.

module line_cmd_queue
    import line_cmd_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_we,
    input  logic [2:0]       cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic             q_full,
    output logic [AW:0]      q_count,
    output logic             q_overflow,
    output logic             q_idle,
    line_cmd_queue_if.master le
);

    // Staging registers.
    logic [31:0] color_q;
    logic [9:0]  x0_q, y0_q, x1_q, y1_q;
    logic        ovf_q;

    logic        go, clr;
    logic        fifo_pop, fifo_full, fifo_empty;
    logic [LQ_ENTRY_W-1:0] fifo_rdata;
    lq_entry_t   head;
    logic        skip_hit;

    // Drain FSM and registered engine outputs.
    logic [2:0]  state_q, state_d;
    lq_pts_t     cur_q, cur_d;
    logic [31:0] le_color_q, le_color_d;
    logic [9:0]  le_point_q, le_point_d;
    logic [4:0]  vld_q, vld_d;
    logic        trig_q, trig_d;

    assign go  = cpu_we && (cpu_addr == LQ_A_GO);
    assign clr = cpu_we && (cpu_addr == LQ_A_CLR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_q <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
        end else if (cpu_we) begin
            case (cpu_addr)
                LQ_A_COLOR: color_q <= cpu_wdata;
                LQ_A_X0:    x0_q    <= cpu_wdata[9:0];
                LQ_A_Y0:    y0_q    <= cpu_wdata[9:0];
                LQ_A_X1:    x1_q    <= cpu_wdata[9:0];
                LQ_A_Y1:    y1_q    <= cpu_wdata[9:0];
                default:    ;
            endcase
        end
    end

    // A GO on a full FIFO is only dropped if the FSM is not popping in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (go && fifo_full && !fifo_pop) begin
            ovf_q <= 1'b1;
        end else if (clr) begin
            ovf_q <= 1'b0;
        end
    end

    line_cmd_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (LQ_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (go),
        .pop   (fifo_pop),
        .wdata (lq_pack(color_q, x0_q, y0_q, x1_q, y1_q)),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (q_count)
    );

    assign head     = lq_entry_t'(fifo_rdata);
    assign fifo_pop = (state_q == LQ_ST_IDLE) && !fifo_empty && le.LE_ready;

`ifdef LQ_SKIP_COLOR_EN
    logic [31:0] last_color_q;
    logic        last_color_vld_q;

    assign skip_hit = last_color_vld_q && (head.color == last_color_q);

    // Tracks the colour the engine last latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_color_q     <= '0;
            last_color_vld_q <= 1'b0;
        end else if (fifo_pop && !skip_hit) begin
            last_color_q     <= head.color;
            last_color_vld_q <= 1'b1;
        end
    end
`else
    assign skip_hit = 1'b0;
`endif

    // Next-state values load the outputs shown while in that state, so every LE_* is registered.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        le_color_d = le_color_q;
        le_point_d = le_point_q;
        vld_d      = '0;
        trig_d     = 1'b0;
        case (state_q)
            LQ_ST_IDLE: begin
                if (fifo_pop) begin
                    cur_d = head.pts;
                    if (skip_hit) begin
                        state_d    = LQ_ST_X0;
                        le_point_d = head.pts.x0;
                        vld_d      = LQ_V_X0;
                    end else begin
                        state_d    = LQ_ST_COLOR;
                        le_color_d = head.color;
                        vld_d      = LQ_V_COLOR;
                    end
                end
            end
            LQ_ST_COLOR: begin
                state_d    = LQ_ST_X0;
                le_point_d = cur_q.x0;
                vld_d      = LQ_V_X0;
            end
            LQ_ST_X0: begin
                state_d    = LQ_ST_Y0;
                le_point_d = cur_q.y0;
                vld_d      = LQ_V_Y0;
            end
            LQ_ST_Y0: begin
                state_d    = LQ_ST_X1;
                le_point_d = cur_q.x1;
                vld_d      = LQ_V_X1;
            end
            LQ_ST_X1: begin
                state_d    = LQ_ST_Y1T;
                le_point_d = cur_q.y1;
                vld_d      = LQ_V_Y1;
                trig_d     = 1'b1;
            end
            // Engine ready may still read high here, so the gap cycle never pops.
            LQ_ST_Y1T: state_d = LQ_ST_GAP;
            LQ_ST_GAP: state_d = LQ_ST_IDLE;
            default:   state_d = LQ_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LQ_ST_IDLE;
            cur_q      <= '0;
            le_color_q <= '0;
            le_point_q <= '0;
            vld_q      <= '0;
            trig_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            le_color_q <= le_color_d;
            le_point_q <= le_point_d;
            vld_q      <= vld_d;
            trig_q     <= trig_d;
        end
    end

    assign le.LE_color       = le_color_q;
    assign le.LE_point       = le_point_q;
    assign le.LE_color_valid = vld_q[4];
    assign le.LE_x0_valid    = vld_q[3];
    assign le.LE_y0_valid    = vld_q[2];
    assign le.LE_x1_valid    = vld_q[1];
    assign le.LE_y1_valid    = vld_q[0];
    assign le.LE_trigger     = trig_q;

    assign q_full     = fifo_full;
    assign q_overflow = ovf_q;
    assign q_idle     = fifo_empty && (state_q == LQ_ST_IDLE) && le.LE_ready;

endmodule

// File: tb/tb_line_cmd_queue.sv
// Testbench for line_cmd_queue: directed scenarios plus a randomized phase, checked against a
// queue-based reference model and a protocol monitor on the LineEngine bus.

module tb_line_cmd_queue;

    localparam int unsigned DEPTH = 8;
`ifdef LQ_SKIP_COLOR_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_we;
    logic [2:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        q_full;
    logic [3:0]  q_count;
    logic        q_overflow;
    logic        q_idle;

    line_cmd_queue_if le_if();

    line_cmd_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .q_full     (q_full),
        .q_count    (q_count),
        .q_overflow (q_overflow),
        .q_idle     (q_idle),
        .le         (le_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] c;
        logic [9:0]  x0;
        logic [9:0]  y0;
        logic [9:0]  x1;
        logic [9:0]  y1;
    } cmd_t;

    cmd_t        stg;
    cmd_t        exp_q[$];
    bit          exp_ovf;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          pulse_cnt = 0;
    int          cyc = 0;
    int          last_trig = 0;
    int          trig_gap_q[$];
    bit          chk_cnt_on_start = 1'b0;

    // Monitor-side model state.
    int          ph = 0;
    cmd_t        mon_cur;
    logic [31:0] mon_color = '0;
    logic [31:0] mdl_last_color = '0;
    bit          mdl_last_vld = 1'b0;

    task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: every pulse must follow the serial load order for the next expected command.
    always @(negedge clk) begin
        logic [4:0] v;
        bit         skip;
        cyc++;
        v = {le_if.LE_color_valid, le_if.LE_x0_valid, le_if.LE_y0_valid, le_if.LE_x1_valid,
             le_if.LE_y1_valid};
        if (!rst_n) begin
            ph           = 0;
            mon_color    = '0;
            mdl_last_vld = 1'b0;
        end else begin
            if (v != 5'b0) pulse_cnt++;
            case (ph)
                0: if (v != 5'b0) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_cmd", 72'(v), 72'd0);
                    end else begin
                        mon_cur = exp_q.pop_front();
                        if (chk_cnt_on_start) check_eq("count_at_start", 72'(q_count),
                                                       72'(exp_q.size()));
                        skip = SKIP_EN && mdl_last_vld && (mon_cur.c == mdl_last_color);
                        if (skip) begin
                            check_eq("start_x0", {v, le_if.LE_trigger, le_if.LE_point},
                                     {5'b01000, 1'b0, mon_cur.x0});
                            ph = 2;
                        end else begin
                            mon_color      = mon_cur.c;
                            mdl_last_color = mon_cur.c;
                            mdl_last_vld   = 1'b1;
                            check_eq("start_color", {v, le_if.LE_trigger, le_if.LE_color},
                                     {5'b10000, 1'b0, mon_cur.c});
                            ph = 1;
                        end
                    end
                end
                1: begin
                    check_eq("x0", {v, le_if.LE_trigger, le_if.LE_point},
                             {5'b01000, 1'b0, mon_cur.x0});
                    ph = 2;
                end
                2: begin
                    check_eq("y0", {v, le_if.LE_trigger, le_if.LE_point},
                             {5'b00100, 1'b0, mon_cur.y0});
                    ph = 3;
                end
                3: begin
                    check_eq("x1", {v, le_if.LE_trigger, le_if.LE_point},
                             {5'b00010, 1'b0, mon_cur.x1});
                    ph = 4;
                end
                4: begin
                    check_eq("y1_trig", {v, le_if.LE_trigger, le_if.LE_point},
                             {5'b00001, 1'b1, mon_cur.y1});
                    trig_gap_q.push_back(cyc - last_trig);
                    last_trig = cyc;
                    done_cnt++;
                    ph = 5;
                end
                default: begin
                    check_eq("gap", {v, le_if.LE_trigger}, 6'b0);
                    ph = 0;
                end
            endcase
            check_eq("color_hold", 72'(le_if.LE_color), 72'(mon_color));
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        case (a)
            3'd0: stg.c  = d;
            3'd1: stg.x0 = d[9:0];
            3'd2: stg.y0 = d[9:0];
            3'd3: stg.x1 = d[9:0];
            3'd4: stg.y1 = d[9:0];
            3'd5: if (exp_q.size() < DEPTH) exp_q.push_back(stg); else exp_ovf = 1'b1;
            3'd6: exp_ovf = 1'b0;
            default: ;
        endcase
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    task automatic set_line(input logic [31:0] c, input logic [31:0] x0, input logic [31:0] y0,
                            input logic [31:0] x1, input logic [31:0] y1);
        wr(3'd0, c);
        wr(3'd1, x0);
        wr(3'd2, y0);
        wr(3'd3, x1);
        wr(3'd4, y1);
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 72'(done_cnt), 72'(target));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  d0;
        int  p0;
        int  base;
        bit  found;
        int  op;
        int  npush;

        rst_n          = 1'b0;
        cpu_we         = 1'b0;
        cpu_addr       = '0;
        cpu_wdata      = '0;
        le_if.LE_ready = 1'b1;
        stg            = '0;
        exp_ovf        = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check_eq("rst_status", {q_full, q_count, q_overflow}, 6'b0);
        check_eq("rst_le", {le_if.LE_color, le_if.LE_point, le_if.LE_color_valid,
                 le_if.LE_x0_valid, le_if.LE_y0_valid, le_if.LE_x1_valid, le_if.LE_y1_valid,
                 le_if.LE_trigger}, 72'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_after_rst", 72'(q_idle), 72'd1);

        // 1: single command, 1-cycle minimum latency from GO.
        d0 = done_cnt;
        set_line(32'h007F_0000, 32'h100, 32'h0, 32'h100, 32'h100);
        wr(3'd5, 32'h0);
        check_eq("t1_count", 72'(q_count), 72'd1);
        check_eq("t1_lat0", 72'(le_if.LE_color_valid), 72'd0);
        @(negedge clk);
        check_eq("t1_lat1", 72'(le_if.LE_color_valid), 72'd1);
        wait_done(d0 + 1, 20, "t1_done");

        // 2: queue three while the engine is busy, then drain in order.
        d0 = done_cnt;
        le_if.LE_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr(3'd1, 32'h20 + 32'(i));
            wr(3'd5, 32'h0);
        end
        p0 = pulse_cnt;
        repeat (20) @(negedge clk);
        check_eq("t2_no_pulses", 72'(pulse_cnt), 72'(p0));
        check_eq("t2_count", 72'(q_count), 72'd3);
        chk_cnt_on_start = 1'b1;
        le_if.LE_ready   = 1'b1;
        wait_done(d0 + 3, 40, "t2_done");
        chk_cnt_on_start = 1'b0;

        // 3: fill past DEPTH with the engine held off.
        le_if.LE_ready = 1'b0;
        set_line(32'h0000_00AA, 32'h3FF, 32'h001, 32'h002, 32'h3FE);
        repeat (9) wr(3'd5, 32'h0);
        check_eq("t3_full", 72'(q_full), 72'd1);
        check_eq("t3_count", 72'(q_count), 72'(DEPTH));
        check_eq("t3_ovf", 72'(q_overflow), 72'(exp_ovf));
        wr(3'd6, 32'h0);
        check_eq("t3_clr", 72'(q_overflow), 72'(exp_ovf));

        // 4: GO lands in the same cycle the FSM pops from a full FIFO.
        d0 = done_cnt;
        set_line(32'hFFFF_FFFF, 32'h155, 32'h2AA, 32'h0F0, 32'h00F);
        le_if.LE_ready = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 3'd5;
        cpu_wdata = 32'h0;
        exp_q.push_back(stg);
        @(negedge clk);
        cpu_we = 1'b0;
        check_eq("t4_count", 72'(q_count), 72'(DEPTH));
        check_eq("t4_ovf", 72'(q_overflow), 72'd0);
        check_eq("t4_full", 72'(q_full), 72'd1);
        wait_done(d0 + 9, 100, "t4_done");

        // 6: back-to-back colour reuse; trigger spacing shows whether COLOR was skipped.
        d0 = done_cnt;
        base = trig_gap_q.size();
        le_if.LE_ready = 1'b0;
        set_line(32'h00AB_CDEF, 32'h1, 32'h2, 32'h3, 32'h4);
        wr(3'd5, 32'h0);
        wr(3'd1, 32'h11);
        wr(3'd5, 32'h0);
        wr(3'd0, 32'h0000_0123);
        wr(3'd5, 32'h0);
        le_if.LE_ready = 1'b1;
        wait_done(d0 + 3, 40, "t6_done");
        check_eq("t6_ngaps", 72'(trig_gap_q.size()), 72'(base + 3));
        if (trig_gap_q.size() >= base + 3) begin
            check_eq("t6_same_color_gap", 72'(trig_gap_q[base + 1]), SKIP_EN ? 72'd6 : 72'd7);
            check_eq("t6_new_color_gap", 72'(trig_gap_q[base + 2]), 72'd7);
        end

        // 5: reset while in X1 abandons the command and flushes the queue.
        d0 = done_cnt;
        set_line(32'h0000_5555, 32'h10, 32'h20, 32'h30, 32'h40);
        wr(3'd5, 32'h0);
        wr(3'd5, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (le_if.LE_x1_valid) found = 1'b1;
        end
        check_eq("t5_reach_x1", 72'(found), 72'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_le_zero", {le_if.LE_color, le_if.LE_point, le_if.LE_color_valid,
                 le_if.LE_x0_valid, le_if.LE_y0_valid, le_if.LE_x1_valid, le_if.LE_y1_valid,
                 le_if.LE_trigger}, 72'd0);
        check_eq("t5_count", 72'(q_count), 72'd0);
        exp_q.delete();
        stg     = '0;
        exp_ovf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pulse_cnt;
        repeat (20) @(negedge clk);
        check_eq("t5_silent", 72'(pulse_cnt), 72'(p0));
        check_eq("t5_idle", 72'(q_idle), 72'd1);
        check_eq("t5_done_unchanged", 72'(done_cnt), 72'(d0));
        wr(3'd5, 32'h0);
        wait_done(d0 + 1, 20, "t5_zero_line");

        // Randomized traffic: GO only issued when the model says it cannot overflow.
        d0 = done_cnt;
        npush = 0;
        for (int i = 0; i < 800; i++) begin
            le_if.LE_ready = ($urandom_range(0, 3) != 0);
            op = $urandom_range(0, 11);
            if (op == 0) begin
                wr(3'd0, 32'($urandom_range(0, 2)));
            end else if (op <= 4) begin
                wr(3'(op), $urandom);
            end else if (op == 5 && exp_q.size() < DEPTH) begin
                wr(3'd5, $urandom);
                npush++;
            end else if (op == 6 || op == 7) begin
                wr(3'(op), $urandom);
            end else begin
                @(negedge clk);
            end
        end
        le_if.LE_ready = 1'b1;
        wait_done(d0 + npush, 8 * 7 + 20, "rand_done");
        check_eq("rand_count", 72'(q_count), 72'd0);
        check_eq("rand_ovf", 72'(q_overflow), 72'd0);
        check_eq("rand_idle", 72'(q_idle), 72'd1);
        check_eq("rand_model_empty", 72'(exp_q.size()), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
